tpg_sequencer: RTL and testbench
================================

Name: tpg_sequencer

Overview:
- Controls the 8-bit test-pattern LFSR: loads a seed, issues a programmed number of patterns to a downstream consumer through a valid/ready handshake, then reports completion.
- Sits between the BIST control logic (start/abort/seed/count) and the circuit-under-test input.
- Owns the LFSR state; the LFSR advances only on an accepted transfer.

Parameters:
- CNT_W, 16, width of the pattern-count and pattern-index fields.
- DEFAULT_SEED, 8'hFF, seed used after reset and substituted for an illegal all-zero seed.

Ports:
- clk  in  1  clock, rising edge.
- set  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- seed  in  8  seed value, sampled on the cycle start is accepted.
- num_pat  in  CNT_W  number of patterns to issue, sampled with start.
- abort  in  1  terminates a run in progress.
- pat_data  out  8  current pattern.
- pat_valid  out  1  pat_data is valid.
- pat_ready  in  1  consumer accepts pat_data when it is high together with pat_valid.
- pat_idx  out  CNT_W  index of the pattern on pat_data, 0-based.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse when a run completes normally.

Behaviour:
- One clock, clk. Reset set is synchronous and active-high: all state updates on the rising edge of clk; set has priority over every other input.
- Values while set is high:
  - state = IDLE.
  - pat_data = DEFAULT_SEED.
  - pat_valid, busy, done = 0.
  - pat_idx = 0.
  - internal count and num_pat latch = 0.
- LFSR advance rule, with p = pat_data: p_next = {p[7]^p[0], p[7:1]}.
  - Example: FF -> 7F -> BF -> 5F.
  - The period is not assumed maximal.
- States:
  - IDLE: start=1 latches num_pat and seed, then goes to LOAD. If the seed is 8'h00, DEFAULT_SEED is loaded instead, because zero locks the LFSR.
  - LOAD: takes 1 cycle. pat_data is loaded with the seed and pat_idx cleared. If the latched num_pat = 0, go to DONE; otherwise go to RUN.
  - RUN: pat_valid = 1.
    - On transfer (pat_valid & pat_ready), pat_data advances and pat_idx increments.
    - If the transfer is pattern num_pat-1, go to DONE instead.
    - With no transfer, pat_data and pat_idx are held stable (no change while valid & !ready).
  - DONE: done = 1 for exactly one cycle, pat_valid = 0, then go to IDLE. pat_data keeps its last advanced value.
- Latency:
  - start at cycle N.
  - LOAD at N+1.
  - First pat_valid at N+2.
  - With pat_ready held high, num_pat transfers occur on consecutive cycles, and done is seen the cycle after the last transfer.
- Boundary conditions:
  - start outside IDLE is ignored, including in DONE.
  - abort in LOAD or RUN goes to IDLE next cycle. pat_valid drops that edge, no done is produced, and a transfer in the same cycle is discarded (no advance). abort in IDLE or DONE is ignored.
  - start and abort together in IDLE: start wins.
  - num_pat = max (all ones) runs 2^CNT_W-1 patterns; the counter never wraps.
  - set asserted mid-run returns to reset values next edge. No done is produced.
  - seed and num_pat changes after start have no effect on the current run.

Decomposition:
- Package tpg_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - LFSR_W = 8 and the DEFAULT_SEED constant;
  - function lfsr_next(8-bit) returning the advance rule above.
- Sub-module tpg_lfsr8:
  - holds the 8-bit pattern register, with ports clk, set, load, load_val, adv, q;
  - load has priority over adv.
- tpg_sequencer holds the FSM, counter and handshake, and instantiates one tpg_lfsr8.

Test Plan:
1. Reset, then start with seed=FF, num_pat=4, pat_ready=1 -> pat_data FF,7F,BF,5F with pat_idx 0..3 on consecutive cycles; done pulse 1 cycle later; busy then 0.
2. seed=00, num_pat=2 -> first pattern FF, second 7F (substitution of DEFAULT_SEED).
3. num_pat=3, pat_ready toggling 1,0,0,1,1 -> data and index held stable during the ready=0 cycles; exactly 3 transfers; done after the third transfer.
4. num_pat=0 -> LOAD then DONE; pat_valid never asserted; done pulses at cycle N+2.
5. num_pat=10, abort after 3 transfers with pat_ready=1 -> pat_valid low next cycle, no done, state IDLE; a new start with seed=BF restarts at BF, pat_idx 0.
6. set pulsed mid-RUN; start held high during RUN and DONE -> outputs at reset values after set; starts outside IDLE have no effect.

Source files
------------

// File: rtl/tpg_pkg.sv
// rtl/tpg_pkg.sv - shared types, constants and LFSR step for the test-pattern sequencer
package tpg_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } tpg_state_e;

    // One LFSR step: feedback of the two end taps shifted in at the top.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] p);
        return {p[7] ^ p[0], p[7:1]};
    endfunction

endpackage

// File: rtl/tpg_lfsr8.sv
// rtl/tpg_lfsr8.sv - 8-bit pattern register with seed load and single-step advance
module tpg_lfsr8
    import tpg_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              set,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              adv,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Load wins over advance; otherwise hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (adv) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // Pattern register with synchronous reset to the default seed.
    always_ff @(posedge clk) begin
        if (set) begin
            lfsr_q <= RESET_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/tpg_sequencer.sv
// rtl/tpg_sequencer.sv - seeds the pattern LFSR and issues a counted run over valid/ready
module tpg_sequencer
    import tpg_pkg::*;
#(
    parameter int                CNT_W        = 16,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = tpg_pkg::DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              set,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed,
    input  logic [CNT_W-1:0]  num_pat,
    input  logic              abort,
    output logic [LFSR_W-1:0] pat_data,
    output logic              pat_valid,
    input  logic              pat_ready,
    output logic [CNT_W-1:0]  pat_idx,
    output logic              busy,
    output logic              done
);

    tpg_state_e        state_q;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  num_q;
    logic [LFSR_W-1:0] seed_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic              xfer;

    // A transfer aborted in the same cycle is discarded, so it never advances the LFSR.
    assign xfer      = (state_q == RUN) && valid_q && pat_ready && !abort;
    assign lfsr_load = (state_q == LOAD);
    assign lfsr_adv  = xfer;

    tpg_lfsr8 #(
        .RESET_VAL (DEFAULT_SEED)
    ) u_lfsr (
        .clk      (clk),
        .set      (set),
        .load     (lfsr_load),
        .load_val (seed_q),
        .adv      (lfsr_adv),
        .q        (pat_data)
    );

    // Run control: seed/count latch, pattern index and registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (set) begin
            state_q <= IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            seed_q  <= DEFAULT_SEED;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        num_q   <= num_pat;
                        // An all-zero seed would lock the LFSR at zero.
                        seed_q  <= (seed == '0) ? DEFAULT_SEED : seed;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= '0;
                        if (num_q == '0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            valid_q <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (xfer) begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == num_q - 1'b1) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pat_valid = valid_q;
    assign pat_idx   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tpg_sequencer.sv
// tb/tb_tpg_sequencer.sv - directed vector bench for the test-pattern sequencer
module tb_tpg_sequencer;

    logic        clk;
    logic        set;
    logic        start;
    logic [7:0]  seed;
    logic [15:0] num_pat;
    logic        abort;
    logic [7:0]  pat_data;
    logic        pat_valid;
    logic        pat_ready;
    logic [15:0] pat_idx;
    logic        busy;
    logic        done;

    int n_tests;
    int n_fail;

    tpg_sequencer #(
        .CNT_W        (16),
        .DEFAULT_SEED (8'hFF)
    ) dut (
        .clk       (clk),
        .set       (set),
        .start     (start),
        .seed      (seed),
        .num_pat   (num_pat),
        .abort     (abort),
        .pat_data  (pat_data),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_idx   (pat_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        set;
        logic        start;
        logic [7:0]  seed;
        logic [15:0] num;
        logic        abort;
        logic        ready;
        logic [7:0]  e_data;
        logic        e_valid;
        logic [15:0] e_idx;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic st, input logic [7:0] sd, input logic [15:0] n,
                       input logic ab, input logic rd, input logic [7:0] ed, input logic ev,
                       input logic [15:0] ei, input logic eb, input logic edn);
        vec_t v;
        v.set = s; v.start = st; v.seed = sd; v.num = n; v.abort = ab; v.ready = rd;
        v.e_data = ed; v.e_valid = ev; v.e_idx = ei; v.e_busy = eb; v.e_done = edn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic st, input logic [7:0] sd, input logic [15:0] n,
                         input logic ab, input logic rd);
        set = s; start = st; seed = sd; num_pat = n; abort = ab; pat_ready = rd;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ed, input logic ev,
                           input logic [15:0] ei, input logic eb, input logic edn);
        chk({tag, ".data"},  {24'd0, pat_data}, {24'd0, ed});
        chk({tag, ".valid"}, {31'd0, pat_valid}, {31'd0, ev});
        chk({tag, ".idx"},   {16'd0, pat_idx}, {16'd0, ei});
        chk({tag, ".busy"},  {31'd0, busy}, {31'd0, eb});
        chk({tag, ".done"},  {31'd0, done}, {31'd0, edn});
    endtask

    initial begin
        int cnt;
        int budget;
        logic [15:0] last_idx;
        n_tests = 0;
        n_fail  = 0;
        drive(1, 0, 8'h00, 16'd0, 0, 0);

        // reset
        add(1,0,8'h00,16'd0,0,0,  8'hFF,0,16'd0,0,0);
        // 1: seed FF, 4 patterns, ready held
        add(0,1,8'hFF,16'd4,0,1,  8'hFF,0,16'd0,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'hFF,1,16'd0,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'h7F,1,16'd1,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'hBF,1,16'd2,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'h5F,1,16'd3,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'hAF,0,16'd4,0,1);
        add(0,0,8'h00,16'd0,0,1,  8'hAF,0,16'd4,0,0);
        // 2: zero seed substitutes FF
        add(0,1,8'h00,16'd2,0,1,  8'hAF,0,16'd4,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'hFF,1,16'd0,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'h7F,1,16'd1,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'hBF,0,16'd2,0,1);
        add(0,0,8'h00,16'd0,0,0,  8'hBF,0,16'd2,0,0);
        // 3: ready 1,0,0,1,1 with 3 patterns
        add(0,1,8'hFF,16'd3,0,0,  8'hBF,0,16'd2,1,0);
        add(0,0,8'h00,16'd0,0,0,  8'hFF,1,16'd0,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'h7F,1,16'd1,1,0);
        add(0,0,8'h00,16'd0,0,0,  8'h7F,1,16'd1,1,0);
        add(0,0,8'h00,16'd0,0,0,  8'h7F,1,16'd1,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'hBF,1,16'd2,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'h5F,0,16'd3,0,1);
        add(0,0,8'h00,16'd0,0,0,  8'h5F,0,16'd3,0,0);
        // 4: zero count goes LOAD then DONE; start in DONE ignored
        add(0,1,8'h5A,16'd0,0,1,  8'h5F,0,16'd3,1,0);
        add(0,0,8'h00,16'd0,0,1,  8'h5A,0,16'd0,0,1);
        add(0,1,8'h33,16'd5,0,1,  8'h5A,0,16'd0,0,0);
        // abort alone in IDLE ignored; start+abort in IDLE starts
        add(0,0,8'h00,16'd0,1,0,  8'h5A,0,16'd0,0,0);
        add(0,1,8'h11,16'd1,1,0,  8'h5A,0,16'd0,1,0);
        add(0,0,8'h00,16'd0,0,0,  8'h11,1,16'd0,1,0);
        add(0,1,8'h22,16'd9,0,1,  8'h88,0,16'd1,0,1);
        add(0,0,8'h00,16'd0,0,0,  8'h88,0,16'd1,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].set, vecs[i].start, vecs[i].seed, vecs[i].num, vecs[i].abort, vecs[i].ready);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid, vecs[i].e_idx,
                    vecs[i].e_busy, vecs[i].e_done);
        end

        // 5: abort after 3 transfers, then restart with BF
        drive(0, 1, 8'hFF, 16'd10, 0, 1);
        step();
        drive(0, 0, 8'h00, 16'd0, 0, 1);
        step(); step(); step(); step();
        chk_out("abort_pre", 8'h5F, 1, 16'd3, 1, 0);
        abort = 1;
        step();
        abort = 0;
        chk_out("abort_post", 8'h5F, 0, 16'd3, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("abort_nodone%0d", k), {31'd0, done | busy | pat_valid}, 32'd0);
        end
        drive(0, 1, 8'hBF, 16'd2, 0, 1);
        step();
        start = 0;
        step();
        chk_out("restart", 8'hBF, 1, 16'd0, 1, 0);

        // 6: set mid-run, then start held through RUN and DONE
        step();
        chk_out("pre_set", 8'h5F, 1, 16'd1, 1, 0);
        set = 1;
        step();
        chk_out("mid_set", 8'hFF, 0, 16'd0, 0, 0);
        drive(0, 1, 8'h00, 16'd2, 0, 1);
        step();
        chk_out("hold_load", 8'hFF, 0, 16'd0, 1, 0);
        seed = 8'h12; num_pat = 16'd7;
        step();
        chk_out("hold_run0", 8'hFF, 1, 16'd0, 1, 0);
        step();
        chk_out("hold_run1", 8'h7F, 1, 16'd1, 1, 0);
        step();
        chk_out("hold_done", 8'hBF, 0, 16'd2, 0, 1);
        step();
        chk_out("hold_idle", 8'hBF, 0, 16'd2, 0, 0);
        step();
        chk("hold_restart_busy", {31'd0, busy}, 32'd1);
        drive(0, 0, 8'h00, 16'd0, 1, 1);
        step();
        chk("load_abort_busy", {31'd0, busy | pat_valid | done}, 32'd0);

        // max count: 65535 transfers, index reaches FFFF without wrapping
        drive(0, 1, 8'hFF, 16'hFFFF, 0, 1);
        step();
        start = 0;
        cnt = 0;
        budget = 70000;
        last_idx = 16'd0;
        while (!done && budget > 0) begin
            step();
            if (pat_valid) cnt++;
            last_idx = pat_idx;
            budget--;
        end
        chk("max_budget", {31'd0, done}, 32'd1);
        chk("max_count", cnt, 32'd65535);
        chk("max_idx", {16'd0, last_idx}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
